// File: rtl/RV32I_definitions.sv
// Shared RV32I constants and the instruction-fetch FSM state encoding.
package RV32I_definitions;

    localparam int unsigned INSTR_WIDTH = 32;
    localparam logic [INSTR_WIDTH-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/imem_bram.sv
// Instruction memory: one write port, one registered read port, no reset so it maps onto block RAM.
module imem_bram #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/imem_fetch.sv
// Instruction fetch stage: loader-fed instruction memory, one-cycle fetch with stall hold,
// flush squash and out-of-range fault reporting.
module imem_fetch
    import RV32I_definitions::*;
#(
    parameter int unsigned IMEM_ADDR_WIDTH = 10,
    parameter int unsigned REG_DATA_WIDTH  = 32
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic                       Load_Valid,
    input  logic [IMEM_ADDR_WIDTH-1:0] Load_Addr,
    input  logic [INSTR_WIDTH-1:0]     Load_Data,
    input  logic                       Load_Done,
    output logic                       Load_Ready,
    input  logic [REG_DATA_WIDTH-1:0]  PC_In,
    input  logic                       IF_Stall,
    input  logic                       IF_Flush,
    output logic                       Fetch_Ready,
    output logic [INSTR_WIDTH-1:0]     IF_Instruction,
    output logic [REG_DATA_WIDTH-1:0]  IF_PC,
    output logic                       IF_Valid,
    output logic                       IF_Fault
);

    fetch_state_e state_q, state_d;
    logic load_ready_q, load_ready_d;
    logic fetch_ready_q, fetch_ready_d;

    // In-flight fetch: address issued to the RAM last edge, plus the stall hold register.
    logic [REG_DATA_WIDTH-1:0] pc1_q, pc1_d;
    logic                      valid1_q, valid1_d;
    logic                      fault1_q, fault1_d;
    logic [INSTR_WIDTH-1:0]    hold_q, hold_d;
    logic                      use_hold_q, use_hold_d;

    logic [INSTR_WIDTH-1:0]    instr_q, instr_d;
    logic [REG_DATA_WIDTH-1:0] pc_q, pc_d;
    logic                      valid_q, valid_d;
    logic                      fault_q, fault_d;

    logic [INSTR_WIDTH-1:0] rdata;
    logic [INSTR_WIDTH-1:0] stage1_instr;
    logic                   mem_we;
    logic                   pc_in_range;
    logic                   advance;

    // A write coinciding with reset is dropped since the RAM itself has no reset.
    assign mem_we       = Load_Valid && (state_q == LOAD) && !Reset;
    assign pc_in_range  = (PC_In >> IMEM_ADDR_WIDTH) == '0;
    assign stage1_instr = use_hold_q ? hold_q : rdata;
    assign advance      = (state_q == PRIME) || ((state_q == RUN) && !IF_Stall && !IF_Flush);

    imem_bram #(
        .ADDR_WIDTH(IMEM_ADDR_WIDTH),
        .DATA_WIDTH(INSTR_WIDTH)
    ) u_bram (
        .clk_i  (Clk),
        .we_i   (mem_we),
        .waddr_i(Load_Addr),
        .wdata_i(Load_Data),
        .raddr_i(PC_In[IMEM_ADDR_WIDTH-1:0]),
        .rdata_o(rdata)
    );

    always_comb begin
        state_d       = state_q;
        pc1_d         = pc1_q;
        valid1_d      = valid1_q;
        fault1_d      = fault1_q;
        hold_d        = hold_q;
        use_hold_d    = use_hold_q;
        instr_d       = instr_q;
        pc_d          = pc_q;
        valid_d       = valid_q;
        fault_d       = fault_q;

        case (state_q)
            LOAD:    if (Load_Done) state_d = PRIME;
            PRIME:   state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = LOAD;
        endcase
        load_ready_d  = (state_d == LOAD);
        fetch_ready_d = (state_d == RUN);

        if (advance) begin
            pc1_d      = PC_In;
            valid1_d   = 1'b1;
            fault1_d   = !pc_in_range;
            use_hold_d = 1'b0;
        end else if ((state_q == RUN) && !IF_Flush) begin
            hold_d     = stage1_instr;
            use_hold_d = 1'b1;
        end else begin
            valid1_d   = 1'b0;
            use_hold_d = 1'b0;
        end

        // Output stage: flush beats stall; a stall leaves every IF_* register untouched.
        if (state_q != RUN) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
            fault_d = 1'b0;
        end else if (IF_Flush) begin
            instr_d = NOP_INSTR;
            pc_d    = PC_In;
            valid_d = 1'b0;
            fault_d = 1'b0;
        end else if (!IF_Stall) begin
            pc_d    = pc1_q;
            instr_d = (valid1_q && !fault1_q) ? stage1_instr : NOP_INSTR;
            valid_d = valid1_q && !fault1_q;
            fault_d = valid1_q && fault1_q;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q       <= LOAD;
            load_ready_q  <= 1'b1;
            fetch_ready_q <= 1'b0;
            pc1_q         <= '0;
            valid1_q      <= 1'b0;
            fault1_q      <= 1'b0;
            hold_q        <= NOP_INSTR;
            use_hold_q    <= 1'b0;
            instr_q       <= NOP_INSTR;
            pc_q          <= '0;
            valid_q       <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            load_ready_q  <= load_ready_d;
            fetch_ready_q <= fetch_ready_d;
            pc1_q         <= pc1_d;
            valid1_q      <= valid1_d;
            fault1_q      <= fault1_d;
            hold_q        <= hold_d;
            use_hold_q    <= use_hold_d;
            instr_q       <= instr_d;
            pc_q          <= pc_d;
            valid_q       <= valid_d;
            fault_q       <= fault_d;
        end
    end

    assign Load_Ready     = load_ready_q;
    assign Fetch_Ready    = fetch_ready_q;
    assign IF_Instruction = instr_q;
    assign IF_PC          = pc_q;
    assign IF_Valid       = valid_q;
    assign IF_Fault       = fault_q;

endmodule

// File: tb/tb_imem_fetch.sv
// Self-checking bench for imem_fetch: directed scenarios plus randomized fetch traffic
// against a transaction-level model of the fetch stage.
module tb_imem_fetch;

    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam int unsigned DEPTH = 1024;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Load_Valid;
    logic [9:0]  Load_Addr;
    logic [31:0] Load_Data;
    logic        Load_Done;
    logic        Load_Ready;
    logic [31:0] PC_In;
    logic        IF_Stall;
    logic        IF_Flush;
    logic        Fetch_Ready;
    logic [31:0] IF_Instruction;
    logic [31:0] IF_PC;
    logic        IF_Valid;
    logic        IF_Fault;

    int tests = 0;
    int fails = 0;

    // Reference model: memory image, the fetch in flight, and the expected outputs.
    logic [31:0] mem_m [DEPTH];
    bit          infl_v;
    logic [31:0] infl_pc;
    logic [31:0] e_instr, e_pc;
    logic        e_valid, e_fault;
    bit          e_pc_known;

    imem_fetch #(
        .IMEM_ADDR_WIDTH(10),
        .REG_DATA_WIDTH (32)
    ) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .Load_Valid    (Load_Valid),
        .Load_Addr     (Load_Addr),
        .Load_Data     (Load_Data),
        .Load_Done     (Load_Done),
        .Load_Ready    (Load_Ready),
        .PC_In         (PC_In),
        .IF_Stall      (IF_Stall),
        .IF_Flush      (IF_Flush),
        .Fetch_Ready   (Fetch_Ready),
        .IF_Instruction(IF_Instruction),
        .IF_PC         (IF_PC),
        .IF_Valid      (IF_Valid),
        .IF_Fault      (IF_Fault)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check_outputs(input string where);
        chk({where, " instr"}, IF_Instruction, e_instr);
        chk({where, " valid"}, 32'(IF_Valid), 32'(e_valid));
        chk({where, " fault"}, 32'(IF_Fault), 32'(e_fault));
        if (e_pc_known) chk({where, " pc"}, IF_PC, e_pc);
    endtask

    task automatic model_reset();
        infl_v     = 1'b0;
        infl_pc    = '0;
        e_instr    = NOP;
        e_pc       = '0;
        e_pc_known = 1'b1;
        e_valid    = 1'b0;
        e_fault    = 1'b0;
    endtask

    // One loader cycle in LOAD.
    task automatic load_word(input logic v, input logic [9:0] a, input logic [31:0] d, input logic done);
        Load_Valid = v;
        Load_Addr  = a;
        Load_Data  = d;
        Load_Done  = done;
        tick();
        if (v) mem_m[a] = d;
        chk("load_ready", 32'(Load_Ready), done ? 32'd0 : 32'd1);
        chk("load_fetch_ready", 32'(Fetch_Ready), 32'd0);
        chk("load_valid_out", 32'(IF_Valid), 32'd0);
        Load_Valid = 1'b0;
        Load_Done  = 1'b0;
    endtask

    // The single PRIME cycle: the first fetch address goes out; loader traffic must be ignored.
    task automatic prime(input logic [31:0] pc);
        PC_In      = pc;
        IF_Stall   = 1'b0;
        IF_Flush   = 1'b0;
        Load_Valid = 1'b1;
        Load_Addr  = 10'($urandom);
        Load_Data  = $urandom;
        Load_Done  = 1'b1;
        tick();
        infl_v  = 1'b1;
        infl_pc = pc;
        chk("prime_fetch_ready", 32'(Fetch_Ready), 32'd1);
        chk("prime_load_ready", 32'(Load_Ready), 32'd0);
        chk("prime_instr", IF_Instruction, NOP);
        chk("prime_valid", 32'(IF_Valid), 32'd0);
        chk("prime_fault", 32'(IF_Fault), 32'd0);
    endtask

    // One RUN cycle with random loader noise, which must not disturb memory.
    task automatic run_cycle(input logic [31:0] pc, input logic stall, input logic flush, input string where);
        PC_In      = pc;
        IF_Stall   = stall;
        IF_Flush   = flush;
        Load_Valid = 1'($urandom);
        Load_Addr  = 10'($urandom);
        Load_Data  = $urandom;
        Load_Done  = 1'($urandom);
        tick();
        if (flush) begin
            e_instr = NOP; e_pc = pc; e_pc_known = 1'b1; e_valid = 1'b0; e_fault = 1'b0;
            infl_v  = 1'b0;
        end else if (!stall) begin
            if (!infl_v) begin
                e_instr = NOP; e_pc_known = 1'b0; e_valid = 1'b0; e_fault = 1'b0;
            end else if (infl_pc >= DEPTH) begin
                e_instr = NOP; e_pc = infl_pc; e_pc_known = 1'b1; e_valid = 1'b0; e_fault = 1'b1;
            end else begin
                e_instr = mem_m[infl_pc]; e_pc = infl_pc; e_pc_known = 1'b1; e_valid = 1'b1; e_fault = 1'b0;
            end
            infl_v  = 1'b1;
            infl_pc = pc;
        end
        check_outputs(where);
        chk({where, " fetch_ready"}, 32'(Fetch_Ready), 32'd1);
        chk({where, " load_ready"}, 32'(Load_Ready), 32'd0);
    endtask

    initial begin
        Reset = 1'b1; Load_Valid = 1'b0; Load_Addr = '0; Load_Data = '0; Load_Done = 1'b0;
        PC_In = '0; IF_Stall = 1'b0; IF_Flush = 1'b0;
        model_reset();
        #2;
        check_outputs("reset");
        chk("reset load_ready", 32'(Load_Ready), 32'd1);
        chk("reset fetch_ready", 32'(Fetch_Ready), 32'd0);
        tick();
        Reset = 1'b0;

        // Load the whole array, then the directed words at 0..3.
        for (int i = 0; i < int'(DEPTH); i++) load_word(1'b1, 10'(i), $urandom, 1'b0);
        load_word(1'b1, 10'd0, 32'h11, 1'b0);
        load_word(1'b1, 10'd1, 32'h22, 1'b0);
        load_word(1'b1, 10'd2, 32'h33, 1'b0);
        load_word(1'b1, 10'd3, 32'h44, 1'b0);
        load_word(1'b0, 10'd0, 32'h0, 1'b1);
        prime(32'd0);

        run_cycle(32'd1, 1'b0, 1'b0, "run0");
        chk("run0 literal", IF_Instruction, 32'h11);
        run_cycle(32'd2, 1'b0, 1'b0, "run1");
        chk("run1 literal", IF_Instruction, 32'h22);
        for (int i = 0; i < 3; i++) begin
            run_cycle(32'd3, 1'b1, 1'b0, "stall");
            chk("stall literal", IF_Instruction, 32'h22);
            chk("stall pc literal", IF_PC, 32'd1);
        end
        run_cycle(32'd3, 1'b0, 1'b0, "release");
        chk("release literal", IF_Instruction, 32'h33);
        run_cycle(32'd4, 1'b0, 1'b0, "run3");
        chk("run3 literal", IF_Instruction, 32'h44);

        run_cycle(32'd9, 1'b1, 1'b1, "flush_stall");
        run_cycle(32'd2, 1'b0, 1'b0, "post_flush_bubble");
        run_cycle(32'd3, 1'b0, 1'b0, "post_flush");
        chk("post_flush literal", IF_Instruction, 32'h33);

        run_cycle(32'h400, 1'b0, 1'b0, "oor_issue");
        run_cycle(32'h3FF, 1'b0, 1'b0, "oor");
        chk("oor fault literal", 32'(IF_Fault), 32'd1);
        run_cycle(32'd0, 1'b0, 1'b0, "oor_recover");
        chk("oor_recover fault literal", 32'(IF_Fault), 32'd0);

        for (int i = 0; i < 400; i++) begin
            logic [31:0] pc;
            pc = ($urandom_range(0, 7) == 0) ? ($urandom | 32'h400) : 32'($urandom_range(0, DEPTH - 1));
            run_cycle(pc, ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0), "random");
        end

        // Half-cycle reset pulse in RUN: outputs return to reset values without a clock edge.
        @(negedge Clk);
        Reset = 1'b1;
        #2;
        model_reset();
        check_outputs("midrun_reset");
        chk("midrun_reset load_ready", 32'(Load_Ready), 32'd1);
        chk("midrun_reset fetch_ready", 32'(Fetch_Ready), 32'd0);
        #1;
        Reset = 1'b0;

        // A write presented while reset is high at the edge must be discarded.
        Load_Valid = 1'b1; Load_Addr = 10'd8; Load_Data = ~mem_m[8]; Load_Done = 1'b0;
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        Load_Valid = 1'b0;
        chk("reset_write load_ready", 32'(Load_Ready), 32'd1);

        load_word(1'b1, 10'd5, 32'hAB, 1'b1);
        prime(32'd5);
        run_cycle(32'd8, 1'b0, 1'b0, "boundary");
        chk("boundary literal", IF_Instruction, 32'hAB);
        run_cycle(32'd0, 1'b0, 1'b0, "reset_write_dropped");
        run_cycle(32'd1, 1'b0, 1'b0, "reload_keeps0");
        chk("reload_keeps0 literal", IF_Instruction, 32'h11);
        run_cycle(32'd2, 1'b0, 1'b0, "reload_keeps1");
        chk("reload_keeps1 literal", IF_Instruction, 32'h22);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/imem_fetch.md
IMEM_FETCH -- requirements
Module: imem_fetch

Interface
REQ-001 The block SHALL have parameter IMEM_ADDR_WIDTH, default 10, giving the instruction memory word-address width (depth 2^IMEM_ADDR_WIDTH words of 32 bits).
REQ-002 The block SHALL have parameter REG_DATA_WIDTH, default 32, giving the instruction and PC width.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset; the ports are listed below.
- Clk  in  1  sole clock; all state updates on rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Load_Valid  in  1  loader write strobe.
- Load_Addr  in  IMEM_ADDR_WIDTH  loader word address.
- Load_Data  in  32  loader write data.
- Load_Done  in  1  loader finished; start fetching.
- Load_Ready  out  1  block is in LOAD state and accepts writes.
- PC_In  in  32  word-indexed fetch address from the PC register (increments by 1 per instruction).
- IF_Stall  in  1  hold fetch outputs.
- IF_Flush  in  1  jump or branch taken; squash the in-flight fetch.
- Fetch_Ready  out  1  block is in RUN state; the core may release its PC.
- IF_Instruction  out  32  fetched instruction to IF/ID.
- IF_PC  out  32  PC_In value that produced IF_Instruction.
- IF_Valid  out  1  IF_Instruction is a real instruction.
- IF_Fault  out  1  PC_In was out of range for this fetch.

Function
REQ-004 The FSM SHALL have three states, LOAD, PRIME and RUN, and SHALL enter LOAD on reset.
REQ-005 In LOAD: Load_Ready=1; each cycle with Load_Valid=1, mem[Load_Addr] SHALL be written with Load_Data.
REQ-006 In LOAD with Load_Done=1: any same-cycle Load_Valid write SHALL complete, then the FSM SHALL move to PRIME.
REQ-007 PRIME SHALL last exactly one cycle, issue a read of mem[PC_In], then move to RUN; Fetch_Ready SHALL go to 1 on entry to RUN.
REQ-008 In PRIME and RUN, Load_Valid and Load_Done SHALL be ignored; memory contents SHALL be unchanged.
REQ-009 Fetch latency SHALL be one cycle: PC_In sampled at edge N yields IF_Instruction, IF_PC=PC_In, IF_Valid=1 and IF_Fault=0 after edge N+1.
REQ-010 The range check SHALL pass when PC_In[31:IMEM_ADDR_WIDTH]==0; otherwise the result SHALL be IF_Instruction=32'h00000013 (NOP), IF_Valid=0, IF_Fault=1, and IF_PC=PC_In. IF_Fault SHALL NOT be sticky.
REQ-011 While IF_Stall=1 and IF_Flush=0, all IF_* outputs SHALL hold. A hold register SHALL preserve the data across a stall of any length, independent of the memory read port.
REQ-012 IF_Flush=1 at edge N SHALL give, after that edge, IF_Instruction=NOP, IF_Valid=0, IF_Fault=0 and IF_PC=PC_In. IF_Flush SHALL override IF_Stall.
REQ-013 After a flush, the first valid output SHALL correspond to the PC_In sampled at the first edge with IF_Flush=0 and IF_Stall=0.
REQ-014 Outside RUN: IF_Valid=0, IF_Fault=0, IF_Instruction=NOP.
REQ-015 The memory read SHALL be synchronous, with no combinational path from PC_In to any output.

Reset
REQ-016 Reset SHALL force the following values regardless of clock: state=LOAD, Load_Ready=1, Fetch_Ready=0, IF_Instruction=32'h00000013, IF_PC=0, IF_Valid=0, IF_Fault=0.
REQ-017 Reset SHALL NOT clear memory contents. Reset asserted mid-LOAD or mid-RUN SHALL abort the operation and return to LOAD; any write in that cycle SHALL be discarded.

Structure
REQ-018 The constant NOP_INSTR=32'h00000013 and the FSM state enum (LOAD, PRIME, RUN) SHALL be placed in the shared RV32I_definitions package.
REQ-019 The memory array SHALL be a sub-module imem_bram: one write port, one synchronous read port, no reset, inferable as block RAM. imem_fetch SHALL own the FSM, hold register, flush and fault logic.

Verification
REQ-020 The bench SHALL cover the following directed scenarios:
- Load and run: write mem[0..3]=0x11,0x22,0x33,0x44, then assert Load_Done; PC_In=0,1,2,3 in consecutive cycles -> IF_Instruction 0x11..0x44 one cycle later, IF_Valid=1, IF_PC=0..3.
- Stall: in RUN, IF_Stall=1 for 3 cycles while the output shows 0x22 -> 0x22 and IF_PC=1 held for all 3 cycles; 0x33 appears the cycle after release.
- Flush with stall: IF_Flush=1 and IF_Stall=1 together -> NOP, IF_Valid=0 next cycle; PC_In=2 then gives 0x33.
- Out of range: with IMEM_ADDR_WIDTH=10, PC_In=0x400 -> IF_Fault=1, IF_Valid=0, NOP; PC_In=0x3FF next -> IF_Fault=0.
- Load boundary: Load_Valid and Load_Done in the same cycle with addr 5, data 0xAB -> PRIME, then RUN; PC_In=5 returns 0xAB.
- Mid-run reset: pulse Reset for half a cycle in RUN -> outputs take reset values immediately, state=LOAD, Load_Ready=1; after reload, earlier contents are still readable.
